// File: rtl/lsu_arbiter.sv
// Round-robin arbiter that shares the memory_control load/store port between the
// integer LSU (port 0) and the FP LSU (port 1), one access per transaction.
module lsu_arbiter #(
    parameter int unsigned FIRST_PRIO = 0,
    parameter logic [11:0] MAP_TOP    = 12'h5FF
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        r0_req_i,
    input  logic [3:0]  r0_op_i,
    input  logic [11:0] r0_addr_i,
    input  logic [31:0] r0_wdata_i,
    output logic        r0_gnt_o,
    output logic        r0_rvalid_o,
    output logic [31:0] r0_rdata_o,
    output logic        r0_err_o,

    input  logic        r1_req_i,
    input  logic [3:0]  r1_op_i,
    input  logic [11:0] r1_addr_i,
    input  logic [31:0] r1_wdata_i,
    output logic        r1_gnt_o,
    output logic        r1_rvalid_o,
    output logic [31:0] r1_rdata_o,
    output logic        r1_err_o,

    output logic [11:0] mem_addr_o,
    output logic        mem_wren_o,
    output logic [3:0]  mem_op_o,
    output logic [31:0] mem_st_data_o,
    input  logic [31:0] mem_data_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    localparam logic PRIO_RST = (FIRST_PRIO != 0);

    state_t      state_q, state_d;
    logic        prio_q, prio_d;
    logic        port_q, port_d;
    logic [3:0]  op_q, op_d;
    logic [11:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        gnt0, gnt1;
    logic [3:0]  selOp;
    logic [11:0] selAddr;
    logic [31:0] selWdata;
    logic        selValid;
    logic        latchedStore;
    logic        inAccess;
    logic        inResp;

    // Arbitration: a lone request wins outright, a tie goes to the priority holder.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (r0_req_i && (!r1_req_i || !prio_q)) begin
                gnt0 = 1'b1;
            end else if (r1_req_i) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign selOp    = gnt1 ? r1_op_i    : r0_op_i;
    assign selAddr  = gnt1 ? r1_addr_i  : r0_addr_i;
    assign selWdata = gnt1 ? r1_wdata_i : r0_wdata_i;
    assign selValid = (selOp >= 4'd1) && (selOp <= 4'd8) && (selAddr <= MAP_TOP);

    assign latchedStore = (op_q >= 4'd1) && (op_q <= 4'd3);

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        port_d  = port_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    port_d  = gnt1;
                    op_d    = selOp;
                    addr_d  = selAddr;
                    wdata_d = selWdata;
                    prio_d  = ~gnt1;
                    rdata_d = 32'h0;
                    // Bad requests bypass the memory entirely and answer next cycle.
                    if (selValid) begin
                        err_d   = 1'b0;
                        state_d = ACCESS;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            ACCESS: begin
                rdata_d = latchedStore ? 32'h0 : mem_data_i;
                state_d = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            prio_q  <= PRIO_RST;
            port_q  <= 1'b0;
            op_q    <= 4'h0;
            addr_q  <= 12'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            port_q  <= port_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign inAccess = (state_q == ACCESS);
    assign inResp   = (state_q == RESP);

    // The memory port is forced to zero outside ACCESS so no stray write can occur.
    assign mem_addr_o    = inAccess ? addr_q  : 12'h0;
    assign mem_op_o      = inAccess ? op_q    : 4'h0;
    assign mem_st_data_o = inAccess ? wdata_q : 32'h0;
    assign mem_wren_o    = inAccess && latchedStore;

    assign r0_gnt_o    = gnt0;
    assign r1_gnt_o    = gnt1;
    assign r0_rvalid_o = inResp && !port_q;
    assign r1_rvalid_o = inResp && port_q;
    assign r0_rdata_o  = r0_rvalid_o ? rdata_q : 32'h0;
    assign r1_rdata_o  = r1_rvalid_o ? rdata_q : 32'h0;
    assign r0_err_o    = r0_rvalid_o && err_q;
    assign r1_err_o    = r1_rvalid_o && err_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed scenarios with literal expectations plus random
// traffic checked every cycle against a transaction-timeline model.
module tb_lsu_arbiter;

    localparam logic [3:0]  OP_SW    = 4'd3;
    localparam logic [3:0]  OP_LW    = 4'd6;
    localparam logic [11:0] MAP_TOP  = 12'h5FF;
    localparam logic [11:0] SW_ADDR  = 12'h500;
    localparam logic [31:0] SWITCHES = 32'h0000005A;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        r0_req_i = 1'b0, r1_req_i = 1'b0;
    logic [3:0]  r0_op_i = '0, r1_op_i = '0;
    logic [11:0] r0_addr_i = '0, r1_addr_i = '0;
    logic [31:0] r0_wdata_i = '0, r1_wdata_i = '0;
    logic        r0_gnt_o, r1_gnt_o, r0_rvalid_o, r1_rvalid_o, r0_err_o, r1_err_o;
    logic [31:0] r0_rdata_o, r1_rdata_o;
    logic [11:0] mem_addr_o;
    logic        mem_wren_o;
    logic [3:0]  mem_op_o;
    logic [31:0] mem_st_data_o;
    logic [31:0] mem_data_i;

    int checkCount = 0;
    int passCount  = 0;

    lsu_arbiter #(.FIRST_PRIO(0), .MAP_TOP(MAP_TOP)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .r0_req_i(r0_req_i), .r0_op_i(r0_op_i), .r0_addr_i(r0_addr_i), .r0_wdata_i(r0_wdata_i),
        .r0_gnt_o(r0_gnt_o), .r0_rvalid_o(r0_rvalid_o), .r0_rdata_o(r0_rdata_o), .r0_err_o(r0_err_o),
        .r1_req_i(r1_req_i), .r1_op_i(r1_op_i), .r1_addr_i(r1_addr_i), .r1_wdata_i(r1_wdata_i),
        .r1_gnt_o(r1_gnt_o), .r1_rvalid_o(r1_rvalid_o), .r1_rdata_o(r1_rdata_o), .r1_err_o(r1_err_o),
        .mem_addr_o(mem_addr_o), .mem_wren_o(mem_wren_o), .mem_op_o(mem_op_o),
        .mem_st_data_o(mem_st_data_o), .mem_data_i(mem_data_i)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in for memory_control: word store per address, 0x500 reads the switches.
    logic [31:0] envMem [0:4095] = '{default: 32'h0};
    assign mem_data_i = (mem_addr_o == SW_ADDR) ? SWITCHES : envMem[mem_addr_o];
    always @(posedge clk_i) begin
        if (mem_wren_o && mem_addr_o != SW_ADDR) envMem[mem_addr_o] <= mem_st_data_o;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        else passCount++;
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input bit p, input logic [3:0] op, input logic [11:0] addr,
                                 input logic [31:0] wd);
        if (p) begin
            r1_op_i = op; r1_addr_i = addr; r1_wdata_i = wd; r1_req_i = 1'b1;
        end else begin
            r0_op_i = op; r0_addr_i = addr; r0_wdata_i = wd; r0_req_i = 1'b1;
        end
    endtask

    task automatic randomPort(input bit p, input bit granted);
        logic        req;
        logic [3:0]  op;
        logic [11:0] addr;
        int          r;
        req = p ? r1_req_i : r0_req_i;
        if (req && !granted) begin
            if ($urandom_range(0, 15) == 0) begin
                if (p) r1_req_i = 1'b0; else r0_req_i = 1'b0;
            end
            return;
        end
        r = $urandom_range(0, 19);
        if (r == 0)      op = 4'd0;
        else if (r == 1) op = 4'(9 + $urandom_range(0, 6));
        else             op = 4'($urandom_range(1, 8));
        r = $urandom_range(0, 9);
        if (r == 0)      addr = 12'($urandom_range(12'h600, 12'hFFF));
        else if (r == 1) addr = SW_ADDR;
        else             addr = 12'($urandom_range(0, 15) * 4);
        applyStimulus(p, op, addr, $urandom);
        if ($urandom_range(0, 1) == 0) begin
            if (p) r1_req_i = 1'b0; else r0_req_i = 1'b0;
        end
    endtask

    // Timeline model: a grant books the access one cycle later and the response
    // after that (or the response alone for a bad request), and blocks new grants.
    initial begin
        int          cyc, freeAt, accessAt, respAt;
        bit          mPrio, tPort, tErr, pendStore, isStore, valid;
        logic [3:0]  tOp;
        logic [11:0] tAddr;
        logic [31:0] tWdata, tRdata;
        logic [31:0] modelMem [0:4095];
        logic        eG0, eG1, eV0, eV1, eE0, eE1, eWren;
        logic [31:0] eD0, eD1, eSt;
        logic [11:0] eAddr;
        logic [3:0]  eOp;
        for (int i = 0; i < 4096; i++) modelMem[i] = 32'h0;
        cyc = 0; freeAt = 0; accessAt = -1; respAt = -1;
        mPrio = 1'b0; tPort = 1'b0; tErr = 1'b0; pendStore = 1'b0;
        tOp = '0; tAddr = '0; tWdata = '0; tRdata = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            {eG0, eG1, eV0, eV1, eE0, eE1, eWren} = '0;
            eD0 = '0; eD1 = '0; eSt = '0; eAddr = '0; eOp = '0;
            if (!rst_ni) begin
                mPrio = 1'b0; freeAt = 0; accessAt = -1; respAt = -1; pendStore = 1'b0;
            end else begin
                if (pendStore) begin
                    if (tAddr != SW_ADDR) modelMem[tAddr] = tWdata;
                    pendStore = 1'b0;
                end
                if (cyc == respAt) begin
                    if (tPort) begin eV1 = 1'b1; eE1 = tErr; eD1 = tRdata; end
                    else       begin eV0 = 1'b1; eE0 = tErr; eD0 = tRdata; end
                end
                if (cyc == accessAt) begin
                    isStore = (tOp <= 4'd3);
                    eAddr = tAddr; eOp = tOp; eSt = tWdata; eWren = isStore;
                    tRdata = isStore ? 32'h0 : ((tAddr == SW_ADDR) ? SWITCHES : modelMem[tAddr]);
                    pendStore = isStore;
                end
                if (cyc >= freeAt && (r0_req_i || r1_req_i)) begin
                    tPort = (r0_req_i && r1_req_i) ? mPrio : r1_req_i;
                    if (tPort) begin eG1 = 1'b1; tOp = r1_op_i; tAddr = r1_addr_i; tWdata = r1_wdata_i; end
                    else       begin eG0 = 1'b1; tOp = r0_op_i; tAddr = r0_addr_i; tWdata = r0_wdata_i; end
                    mPrio = !tPort;
                    valid = (tOp >= 4'd1) && (tOp <= 4'd8) && (tAddr <= MAP_TOP);
                    tErr = !valid;
                    tRdata = 32'h0;
                    if (valid) begin accessAt = cyc + 1; respAt = cyc + 2; freeAt = cyc + 3; end
                    else       begin accessAt = -1;      respAt = cyc + 1; freeAt = cyc + 2; end
                end
            end
            checkOutput("r0_gnt",    32'(r0_gnt_o),    32'(eG0));
            checkOutput("r1_gnt",    32'(r1_gnt_o),    32'(eG1));
            checkOutput("r0_rvalid", 32'(r0_rvalid_o), 32'(eV0));
            checkOutput("r1_rvalid", 32'(r1_rvalid_o), 32'(eV1));
            checkOutput("r0_err",    32'(r0_err_o),    32'(eE0));
            checkOutput("r1_err",    32'(r1_err_o),    32'(eE1));
            checkOutput("r0_rdata",  r0_rdata_o,       eD0);
            checkOutput("r1_rdata",  r1_rdata_o,       eD1);
            checkOutput("mem_addr",  32'(mem_addr_o),  32'(eAddr));
            checkOutput("mem_op",    32'(mem_op_o),    32'(eOp));
            checkOutput("mem_wren",  32'(mem_wren_o),  32'(eWren));
            checkOutput("mem_st",    mem_st_data_o,    eSt);
        end
    end

    initial begin
        int   nGnt;
        int   gntPort [6];
        int   gntCyc [6];
        logic g0, g1;

        // Reset values.
        rst_ni = 1'b0;
        @(negedge clk_i);
        checkOutput("reset_gnt",    32'({r0_gnt_o, r1_gnt_o}), 32'h0);
        checkOutput("reset_rvalid", 32'({r0_rvalid_o, r1_rvalid_o, r0_err_o, r1_err_o}), 32'h0);
        checkOutput("reset_wren",   32'(mem_wren_o), 32'h0);
        nextCycle();
        rst_ni = 1'b1;

        // Store then load back through port 0.
        applyStimulus(0, OP_SW, 12'h010, 32'hDEADBEEF);
        @(negedge clk_i);
        checkOutput("sw_gnt", 32'(r0_gnt_o), 32'h1);
        checkOutput("sw_wren_at_gnt", 32'(mem_wren_o), 32'h0);
        nextCycle(); r0_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("sw_wren", 32'(mem_wren_o), 32'h1);
        checkOutput("sw_addr", 32'(mem_addr_o), 32'h010);
        checkOutput("sw_data", mem_st_data_o, 32'hDEADBEEF);
        nextCycle();
        @(negedge clk_i);
        checkOutput("sw_rvalid", 32'(r0_rvalid_o), 32'h1);
        checkOutput("sw_wren_resp", 32'(mem_wren_o), 32'h0);
        nextCycle();
        applyStimulus(0, OP_LW, 12'h010, 32'h0);
        @(negedge clk_i);
        checkOutput("lw_gnt", 32'(r0_gnt_o), 32'h1);
        nextCycle(); r0_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("lw_rvalid_early", 32'(r0_rvalid_o), 32'h0);
        nextCycle();
        @(negedge clk_i);
        checkOutput("lw_rvalid", 32'(r0_rvalid_o), 32'h1);
        checkOutput("lw_rdata", r0_rdata_o, 32'hDEADBEEF);
        nextCycle();

        // Invalid ops on port 1 answer one cycle after grant without memory traffic.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, (k == 0) ? 4'd0 : 4'd9, 12'h010, 32'h12345678);
            @(negedge clk_i);
            checkOutput("badop_gnt", 32'(r1_gnt_o), 32'h1);
            nextCycle(); r1_req_i = 1'b0;
            @(negedge clk_i);
            checkOutput("badop_rvalid", 32'(r1_rvalid_o), 32'h1);
            checkOutput("badop_err", 32'(r1_err_o), 32'h1);
            checkOutput("badop_rdata", r1_rdata_o, 32'h0);
            checkOutput("badop_wren", 32'(mem_wren_o), 32'h0);
            nextCycle();
        end

        // Unmapped address on port 0, then switches read on port 1.
        applyStimulus(0, OP_LW, 12'h700, 32'h0);
        @(negedge clk_i);
        checkOutput("unmapped_gnt", 32'(r0_gnt_o), 32'h1);
        nextCycle(); r0_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("unmapped_err", 32'({r0_rvalid_o, r0_err_o}), 32'h3);
        checkOutput("unmapped_no_access", 32'(mem_op_o), 32'h0);
        nextCycle();
        applyStimulus(1, OP_LW, SW_ADDR, 32'h0);
        @(negedge clk_i);
        checkOutput("switch_gnt", 32'(r1_gnt_o), 32'h1);
        nextCycle(); r1_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("switch_access_addr", 32'(mem_addr_o), 32'h500);
        nextCycle();
        @(negedge clk_i);
        checkOutput("switch_rdata", r1_rdata_o, 32'h0000005A);
        checkOutput("switch_err", 32'({r1_rvalid_o, r1_err_o}), 32'h2);
        nextCycle();

        // Both ports requesting continuously after reset: strict alternation from port 0.
        rst_ni = 1'b0;
        nextCycle();
        rst_ni = 1'b1;
        applyStimulus(0, OP_LW, 12'h020, 32'h0);
        applyStimulus(1, OP_LW, 12'h024, 32'h0);
        nGnt = 0;
        for (int c = 0; c < 30 && nGnt < 6; c++) begin
            @(negedge clk_i);
            if (r0_gnt_o || r1_gnt_o) begin
                gntPort[nGnt] = r1_gnt_o ? 1 : 0;
                gntCyc[nGnt]  = c;
                nGnt++;
            end
            nextCycle();
        end
        r0_req_i = 1'b0; r1_req_i = 1'b0;
        checkOutput("fair_count", 32'(nGnt), 32'd6);
        for (int k = 0; k < nGnt; k++) begin
            checkOutput("fair_port", 32'(gntPort[k]), 32'(k % 2));
            if (k > 0) checkOutput("fair_gap", 32'(gntCyc[k] - gntCyc[k-1]), 32'd3);
        end
        repeat (3) nextCycle();

        // Reset in the middle of a store's access cycle.
        applyStimulus(0, OP_SW, 12'h420, 32'hCAFEF00D);
        @(negedge clk_i);
        checkOutput("rst_sw_gnt", 32'(r0_gnt_o), 32'h1);
        nextCycle(); r0_req_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rst_sw_wren", 32'(mem_wren_o), 32'h1);
        #1 rst_ni = 1'b0;
        #1;
        checkOutput("rst_async_wren", 32'(mem_wren_o), 32'h0);
        checkOutput("rst_async_addr", 32'(mem_addr_o), 32'h0);
        nextCycle();
        @(negedge clk_i);
        checkOutput("rst_no_rvalid", 32'(r0_rvalid_o), 32'h0);
        nextCycle();
        rst_ni = 1'b1;
        applyStimulus(0, OP_LW, 12'h420, 32'h0);
        applyStimulus(1, OP_LW, 12'h420, 32'h0);
        @(negedge clk_i);
        checkOutput("rst_prio_gnt", 32'({r0_gnt_o, r1_gnt_o}), 32'h2);
        nextCycle(); r0_req_i = 1'b0;
        nextCycle();
        @(negedge clk_i);
        checkOutput("rst_dropped_store", r0_rdata_o, 32'h0);
        nextCycle();
        @(negedge clk_i);
        checkOutput("rst_second_gnt", 32'(r1_gnt_o), 32'h1);
        nextCycle(); r1_req_i = 1'b0;
        repeat (3) nextCycle();

        // Random traffic, checked by the timeline model.
        $display("[TB] starting random traffic");
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_i);
            g0 = r0_gnt_o;
            g1 = r1_gnt_o;
            nextCycle();
            randomPort(0, g0);
            randomPort(1, g1);
        end
        r0_req_i = 1'b0; r1_req_i = 1'b0;
        repeat (4) nextCycle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
